// File: rtl/lockstep_checker.sv
// Lockstep equivalence checker: compares a reference vector against a (possibly lagging)
// UUT vector each cycle after reset, reporting sticky failure, counters and first-failure data.
module lockstep_checker #(
    parameter int WIDTH        = 8,
    parameter int DELAY        = 0,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ref_vec,
    input  logic [WIDTH-1:0] uut_vec,
    input  logic [WIDTH-1:0] cmp_mask,
    output logic             armed,
    output logic             mismatch,
    output logic             fail,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] first_cycle,
    output logic [WIDTH-1:0] first_diff
);

    typedef enum logic [1:0] {
        UNARMED = 2'd0,
        WARMUP  = 2'd1,
        CHECK   = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic [3:0] WARM_LAST = (DELAY > 0) ? 4'(DELAY - 1) : 4'd0;

    // Power-up values come from initializers: the checker stays silent until a reset is seen.
    state_t           state_r          = UNARMED;
    logic [3:0]       warm_r           = 4'd0;
    logic             armed_r          = 1'b0;
    logic             mismatch_r       = 1'b0;
    logic             fail_r           = 1'b0;
    logic [CNT_W-1:0] mismatch_count_r = '0;
    logic [CNT_W-1:0] cycle_count_r    = '0;
    logic [CNT_W-1:0] first_cycle_r    = '0;
    logic [WIDTH-1:0] first_diff_r     = '0;

    logic [WIDTH-1:0] ref_d_s;
    logic [WIDTH-1:0] diff_s;
    logic             check_s;
    logic             hit_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    generate
        if (DELAY == 0) begin : g_no_delay
            assign ref_d_s = ref_vec;
        end else begin : g_delay
            logic [DELAY-1:0][WIDTH-1:0] line_r = '0;

            // Reference delay line; element DELAY-1 is the oldest sample.
            always_ff @(posedge clk) begin
                if (reset) begin
                    line_r <= '0;
                end else if (state_r == WARMUP || state_r == CHECK) begin
                    line_r[0] <= ref_vec;
                    for (int i = 1; i < DELAY; i++) begin
                        line_r[i] <= line_r[i-1];
                    end
                end else begin
                    line_r <= line_r;
                end
            end

            assign ref_d_s = line_r[DELAY-1];
        end
    endgenerate

    assign diff_s  = (ref_d_s ^ uut_vec) & cmp_mask;
    assign check_s = (state_r == CHECK);
    assign hit_s   = check_s && (diff_s != '0);

    // Checker state machine; armed is registered alongside the state it reflects.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_r <= 4'd0;
            if (DELAY == 0) begin
                state_r <= CHECK;
                armed_r <= 1'b1;
            end else begin
                state_r <= WARMUP;
                armed_r <= 1'b0;
            end
        end else begin
            case (state_r)
                UNARMED: begin
                    state_r <= UNARMED;
                    armed_r <= 1'b0;
                end
                WARMUP: begin
                    warm_r <= warm_r + 4'd1;
                    if (warm_r == WARM_LAST) begin
                        state_r <= CHECK;
                        armed_r <= 1'b1;
                    end else begin
                        state_r <= WARMUP;
                        armed_r <= 1'b0;
                    end
                end
                CHECK: begin
                    armed_r <= 1'b1;
                    if (hit_s && (STOP_ON_FAIL != 0)) begin
                        state_r <= HALT;
                    end else begin
                        state_r <= CHECK;
                    end
                end
                HALT: begin
                    state_r <= HALT;
                    armed_r <= 1'b1;
                end
                default: begin
                    state_r <= UNARMED;
                    armed_r <= 1'b0;
                    warm_r  <= 4'd0;
                end
            endcase
        end
    end

    // Per-compare pulse and saturating cycle / mismatch counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_r    <= '0;
            mismatch_count_r <= '0;
            mismatch_r       <= 1'b0;
        end else if (check_s) begin
            cycle_count_r <= sat_inc(cycle_count_r);
            mismatch_r    <= hit_s;
            if (hit_s) begin
                mismatch_count_r <= sat_inc(mismatch_count_r);
            end else begin
                mismatch_count_r <= mismatch_count_r;
            end
        end else begin
            mismatch_r <= 1'b0;
        end
    end

    // First-failure capture; cycle index is the pre-increment count of this compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            fail_r        <= 1'b0;
            first_cycle_r <= '0;
            first_diff_r  <= '0;
        end else if (hit_s && !fail_r) begin
            fail_r        <= 1'b1;
            first_cycle_r <= cycle_count_r;
            first_diff_r  <= diff_s;
        end else begin
            fail_r <= fail_r;
        end
    end

    assign armed          = armed_r;
    assign mismatch       = mismatch_r;
    assign fail           = fail_r;
    assign mismatch_count = mismatch_count_r;
    assign cycle_count    = cycle_count_r;
    assign first_cycle    = first_cycle_r;
    assign first_diff     = first_diff_r;

endmodule

// File: doc/lockstep_checker.md
# lockstep_checker

Parametrised lockstep equivalence checker for comparing a reference model against a unit under test, both driven from the same stimulus. It compares a packed output vector from each side every cycle, once a reset has been seen. It tolerates a fixed UUT pipeline lag and applies a per-bit compare mask. It reports sticky failure, a mismatch count and first-failure diagnostics, so one block serves every FSM equivalence bench and simulation scoreboard in the design.

## Interface
- WIDTH, 8: width of compared vectors (≥1)
- DELAY, 0: cycles by which uut_vec lags ref_vec (0..15)
- CNT_W, 16: width of cycle and mismatch counters (≥2)
- STOP_ON_FAIL, 0: 1 = freeze all state at first mismatch; 0 = keep checking

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; also arms the checker
- ref_vec  in  WIDTH  reference model outputs, packed
- uut_vec  in  WIDTH  UUT outputs, packed
- cmp_mask  in  WIDTH  1 = bit compared; sampled in the compare cycle
- armed  out  1  1 in CHECK or HALT
- mismatch  out  1  one-cycle pulse, registered result of the previous compare
- fail  out  1  sticky, set at first mismatch
- mismatch_count  out  CNT_W  mismatching compare cycles, saturating at all-ones
- cycle_count  out  CNT_W  completed compare cycles, saturating at all-ones
- first_cycle  out  CNT_W  cycle_count value at first mismatch
- first_diff  out  WIDTH  masked XOR at first mismatch

## Operation
- States:
  - UNARMED: power-up value via initializer; no reset seen yet.
  - WARMUP: filling the delay line.
  - CHECK: comparing every cycle.
  - HALT: frozen after a failure.
- Reset high in any state:
  - next state is WARMUP;
  - warm counter, delay line, all outputs and all counters are cleared to 0.
- UNARMED:
  - no comparison is made; all outputs hold 0;
  - leaves UNARMED only via reset.
- WARMUP:
  - each reset-low cycle shifts ref_vec into a DELAY-deep register line and increments the warm counter;
  - after DELAY reset-low cycles, the next state is CHECK;
  - with DELAY=0 the next state after reset is CHECK directly.
- CHECK, each cycle:
  - ref_d is ref_vec from DELAY cycles earlier (ref_vec itself when DELAY=0);
  - diff = (ref_d ^ uut_vec) & cmp_mask;
  - cycle_count increments, saturating.
- On diff != 0 in CHECK:
  - mismatch = 1 next cycle;
  - mismatch_count increments, saturating.
  - If fail was 0: fail ← 1, first_cycle ← cycle_count (pre-increment), first_diff ← diff.
  - If STOP_ON_FAIL=1, next state is HALT.
- Subsequent mismatches never overwrite first_cycle or first_diff.
- HALT:
  - all counters, first_* and fail are frozen; mismatch returns to 0;
  - leaves HALT only via reset.
- The delay line keeps shifting in CHECK; its contents are irrelevant in HALT.
- cmp_mask = 0 makes every compare pass; cycle_count still advances.

## Timing
- All outputs are registered. Reset values:
  - armed=0, mismatch=0, fail=0;
  - mismatch_count=0, cycle_count=0, first_cycle=0, first_diff=0.
- Let cycle R be the first reset-low cycle after reset.
  - Compares occur in cycles R+DELAY onward.
  - ref_vec sampled in cycle R+k is compared with uut_vec in cycle R+k+DELAY.
- armed rises at the edge ending cycle R+DELAY-1; for DELAY=0, at the edge ending reset.
- Compare in cycle t: mismatch, fail and count updates are visible after the edge ending t (latency 1).
- Reset asserted mid-CHECK or in HALT: takes effect at that edge and overrides a simultaneous mismatch (reset wins).
- Counter saturation: at all-ones the value holds. first_cycle may equal all-ones.
- Reset held for multiple cycles: the block stays in WARMUP with warm counter 0.

## Test plan
- No reset, ref_vec=0x00, uut_vec=0xFF for 10 cycles -> armed=0, fail=0, mismatch_count=0.
- WIDTH=8, DELAY=0: reset, then identical vectors for 20 cycles, uut bit3 flipped at compare index 20 -> mismatch pulse one cycle later, fail=1, first_cycle=20, first_diff=0x08, mismatch_count=1.
- Same as above but cmp_mask=0xF7 -> no mismatch, fail=0, cycle_count=21.
- DELAY=2, uut_vec = ref_vec delayed 2 cycles -> armed after 2 warmup cycles, no fail over 50 cycles. Same run with uut delayed 1 cycle and changing ref -> fail at first differing compare.
- STOP_ON_FAIL=1, mismatch at index 5, then 10 more mismatching cycles -> state HALT, mismatch_count=1, cycle_count=6 frozen. Reset -> all outputs 0, re-arms.
- CNT_W=2, STOP_ON_FAIL=0, 6 consecutive mismatches -> mismatch_count=3, cycle_count=3 (saturated), first_cycle=0. Reset mid-run -> counts cleared next cycle.
